// File: rtl/bk_mem_pkg.sv
// Shared definitions for the SRAM bulk-copy port: scheduler states and address map.
package bk_mem_pkg;

  localparam int COPY_AW = 25;
  localparam logic [COPY_AW-1:0] SRAM_ROM_BASE = 25'h0080000;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_CRD,
    ST_CLAT,
    ST_MWR,
    ST_INC,
    ST_DONE,
    ST_IDLE,
    ST_DISK
  } copy_state_t;

endpackage

// File: rtl/copy_mux.sv
// Owner mux for the SRAM copy port: boot copier or disk controller drives it.
module copy_mux
  import bk_mem_pkg::*;
(
  input  logic               sel_disk,
  input  logic               boot_we,
  input  logic [COPY_AW-1:0] boot_addr,
  input  logic [15:0]        boot_dout,
  input  logic               dsk_virt,
  input  logic [COPY_AW-1:0] dsk_addr,
  input  logic [15:0]        dsk_dout,
  input  logic               dsk_we,
  input  logic               dsk_rd,
  input  logic               mem_ack,
  input  logic [15:0]        mem_din,
  output logic               mem_virt,
  output logic [COPY_AW-1:0] mem_addr,
  output logic [15:0]        mem_dout,
  output logic               mem_we,
  output logic               mem_rd,
  output logic               dsk_ack,
  output logic [15:0]        dsk_din
);

  always_comb begin
    mem_virt = 1'b0;
    mem_addr = boot_addr;
    mem_dout = boot_dout;
    mem_we   = boot_we;
    mem_rd   = 1'b0;
    dsk_ack  = 1'b0;
    dsk_din  = '0;
    if (sel_disk) begin
      mem_virt = dsk_virt;
      mem_addr = dsk_addr;
      mem_dout = dsk_dout;
      mem_we   = dsk_we;
      // a simultaneous write and read from the disk side resolves to the write
      mem_rd   = dsk_rd & ~dsk_we;
      dsk_ack  = mem_ack;
      dsk_din  = mem_din;
    end
  end

endmodule

// File: rtl/sram_copy_sched.sv
// Boot-time ROM-to-SRAM copier and disk arbiter for the SRAM bulk-copy port.
//   state | meaning
//   WAIT  | settle after reset before touching the cache
//   CRD   | two-cycle cache read of the current word
//   CLAT  | capture cache data into the write latch
//   MWR   | SRAM write, held until ack or timeout
//   INC   | advance word, loop or finish
//   DONE  | raise sys_ready, release the CPU
//   IDLE  | boot finished, port free
//   DISK  | disk controller owns the port
module sram_copy_sched
  import bk_mem_pkg::*;
#(
  parameter int                 INIT_WAIT   = 500000,
  parameter int                 WORDS       = 32768,
  parameter logic [COPY_AW-1:0] SRAM_BASE   = SRAM_ROM_BASE,
  parameter int                 ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  output logic [15:0]        cache_addr,
  output logic               cache_rd,
  input  logic [15:0]        cache_q,
  output logic               mem_copy,
  output logic               mem_virt,
  output logic [COPY_AW-1:0] mem_addr,
  output logic [15:0]        mem_dout,
  output logic               mem_we,
  output logic               mem_rd,
  input  logic [15:0]        mem_din,
  input  logic               mem_ack,
  input  logic               dsk_req,
  input  logic               dsk_virt,
  input  logic [COPY_AW-1:0] dsk_addr,
  input  logic [15:0]        dsk_dout,
  input  logic               dsk_we,
  input  logic               dsk_rd,
  output logic               dsk_gnt,
  output logic               dsk_ack,
  output logic [15:0]        dsk_din,
  output logic               sys_ready,
  output logic               cpu_hold,
  output logic               copy_err
);

  localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [15:0]       WORD_LAST = 16'(WORDS - 1);

  copy_state_t        state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [15:0]        word;
  logic               crd_ph;
  logic [15:0]        latch;

  logic               wait_last;
  logic               ack_timeout;
  logic               boot_we;
  logic [COPY_AW-1:0] boot_addr;
  logic [15:0]        boot_dout;

  assign wait_last   = (wait_cnt == WAIT_LAST);
  assign ack_timeout = (state == ST_MWR) && !mem_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_WAIT;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      word      <= '0;
      crd_ph    <= 1'b0;
      latch     <= '0;
      sys_ready <= 1'b0;
      copy_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT && !wait_last) ? wait_cnt + WAIT_W'(1) : '0;
      tmo_cnt  <= (state == ST_MWR) ? tmo_cnt + TMO_W'(1) : '0;
      crd_ph   <= (state == ST_CRD) ? ~crd_ph : 1'b0;
      if (state == ST_CLAT) latch <= cache_q;
      if (state == ST_INC) word <= word + 16'd1;
      if (ack_timeout) copy_err <= 1'b1;
      if (state == ST_DONE) sys_ready <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: if (wait_last) state_nxt = ST_CRD;
      ST_CRD:  if (crd_ph) state_nxt = ST_CLAT;
      ST_CLAT: state_nxt = ST_MWR;
      ST_MWR:  if (mem_ack || ack_timeout) state_nxt = ST_INC;
      ST_INC:  state_nxt = (word == WORD_LAST) ? ST_DONE : ST_CRD;
      // a disk request already pending at DONE is granted without an IDLE cycle
      ST_DONE: state_nxt = dsk_req ? ST_DISK : ST_IDLE;
      ST_IDLE: if (dsk_req) state_nxt = ST_DISK;
      ST_DISK: if (!dsk_req) state_nxt = ST_IDLE;
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_comb begin
    cache_rd   = (state == ST_CRD);
    cache_addr = cache_rd ? {word[14:0], 1'b0} : '0;
    boot_we    = (state == ST_MWR);
    boot_addr  = boot_we ? SRAM_BASE + COPY_AW'({word, 1'b0}) : '0;
    boot_dout  = boot_we ? latch : '0;
    mem_copy   = state inside {ST_CRD, ST_CLAT, ST_MWR, ST_INC, ST_DONE, ST_DISK};
    dsk_gnt    = (state == ST_DISK);
    cpu_hold   = !sys_ready || dsk_gnt;
  end

  copy_mux u_copy_mux (
    .sel_disk  (dsk_gnt),
    .boot_we   (boot_we),
    .boot_addr (boot_addr),
    .boot_dout (boot_dout),
    .dsk_virt  (dsk_virt),
    .dsk_addr  (dsk_addr),
    .dsk_dout  (dsk_dout),
    .dsk_we    (dsk_we),
    .dsk_rd    (dsk_rd),
    .mem_ack   (mem_ack),
    .mem_din   (mem_din),
    .mem_virt  (mem_virt),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .dsk_ack   (dsk_ack),
    .dsk_din   (dsk_din)
  );

endmodule

// File: tb/tb_sram_copy_sched.sv
// Bench for sram_copy_sched: cache/SRAM models, write scoreboard, disk vector table.
module tb_sram_copy_sched;

  localparam int INIT_WAIT   = 4;
  localparam int WORDS       = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam logic [24:0] BASE = 25'h0080000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cache_addr;
  logic        cache_rd;
  logic [15:0] cache_q = '0;
  logic        mem_copy, mem_virt, mem_we, mem_rd;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout;
  logic [15:0] mem_din = '0;
  logic        mem_ack = 1'b0;
  logic        dsk_req = 1'b0, dsk_virt = 1'b0, dsk_we = 1'b0, dsk_rd = 1'b0;
  logic [24:0] dsk_addr = '0;
  logic [15:0] dsk_dout = '0;
  logic        dsk_gnt, dsk_ack, sys_ready, cpu_hold, copy_err;
  logic [15:0] dsk_din;

  sram_copy_sched #(
    .INIT_WAIT(INIT_WAIT), .WORDS(WORDS), .SRAM_BASE(BASE), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cache_addr(cache_addr), .cache_rd(cache_rd),
    .cache_q(cache_q), .mem_copy(mem_copy), .mem_virt(mem_virt), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_we(mem_we), .mem_rd(mem_rd), .mem_din(mem_din),
    .mem_ack(mem_ack), .dsk_req(dsk_req), .dsk_virt(dsk_virt), .dsk_addr(dsk_addr),
    .dsk_dout(dsk_dout), .dsk_we(dsk_we), .dsk_rd(dsk_rd), .dsk_gnt(dsk_gnt),
    .dsk_ack(dsk_ack), .dsk_din(dsk_din), .sys_ready(sys_ready), .cpu_hold(cpu_hold),
    .copy_err(copy_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    int          gap;
  } wr_t;

  typedef struct {
    logic        we, rd, virt;
    logic [24:0] addr;
    logic [15:0] dout;
    logic        x_we, x_rd, x_virt;
    logic [24:0] x_addr;
    logic [15:0] x_dout;
  } vec_t;

  wr_t         exp_q[$];
  vec_t        vt[4];
  logic [15:0] cmem[4];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic        h1_rd = 0, h2_rd = 0, h3_rd = 0;
  logic [15:0] h1_a = '0, h2_a = '0, h3_a = '0;
  int          ack_cnt = 0, ack_lat = 3;
  logic        nak_en = 1'b0;
  logic [24:0] nak_addr = '0;
  logic [15:0] rd_data = '0;
  logic        prev_we = 1'b0;
  int          last_rise = 0, nak_rise = -1, err_cyc = -1, early_gnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // one clock: models react at the falling edge, outputs are checked just after
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    cache_q = (h2_rd && !h3_rd) ? cmem[h2_a[2:1]] : 16'hDEAD;
    h3_rd = h2_rd; h3_a = h2_a;
    h2_rd = h1_rd; h2_a = h1_a;
    h1_rd = cache_rd; h1_a = cache_addr;
    if (mem_we || mem_rd) begin
      ack_cnt++;
      if (ack_cnt == ack_lat && !(nak_en && mem_addr == nak_addr)) begin
        mem_ack = 1'b1; mem_din = rd_data; ack_cnt = 0;
      end else begin
        mem_ack = 1'b0; mem_din = '0;
      end
    end else begin
      ack_cnt = 0; mem_ack = 1'b0; mem_din = '0;
    end
    #1;
    if (mem_we && !prev_we && !dsk_gnt) begin
      chk("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_dout, e.data);
        if (e.gap != 0) chk("wr_gap", cyc - last_rise, e.gap);
      end
      last_rise = cyc;
      if (nak_en && mem_addr == nak_addr) nak_rise = cyc;
    end
    if (copy_err && err_cyc < 0) err_cyc = cyc;
    if (dsk_gnt && !sys_ready) early_gnt++;
    prev_we = mem_we;
  endtask

  // per-word spacing: CRD(2) + CLAT(1) + INC(1) + cycles spent in the previous MWR
  task automatic push_word(input int i, input int prev_mwr);
    wr_t e;
    e.addr = BASE + 25'(2 * i);
    e.data = cmem[i];
    e.gap  = (prev_mwr == 0) ? 0 : 4 + prev_mwr;
    exp_q.push_back(e);
  endtask

  task automatic push_boot(input int nak_idx);
    for (int i = 0; i < WORDS; i++)
      push_word(i, (i == 0) ? 0 : ((i - 1 == nak_idx) ? ACK_TIMEOUT : 3));
  endtask

  task automatic do_reset();
    reset = 1'b1; dsk_req = 1'b0; dsk_we = 1'b0; dsk_rd = 1'b0; nak_en = 1'b0;
    exp_q.delete();
    repeat (3) step();
    err_cyc = -1; nak_rise = -1; early_gnt = 0;
  endtask

  task automatic release_reset(input logic req);
    int n = 0;
    reset = 1'b0;
    dsk_req = req;
    do begin step(); n++; end while (!cache_rd && n < 50);
    chk("wait_cycles", n, INIT_WAIT);
  endtask

  task automatic run_to_ready(input int max);
    int n = 0;
    while (!sys_ready && n < max) begin step(); n++; end
    chk("sys_ready", sys_ready, 1);
  endtask

  initial begin
    int n;
    cmem[0] = 16'h1111; cmem[1] = 16'h2222; cmem[2] = 16'h3333; cmem[3] = 16'h4444;
    //        we rd vt addr          dout       | x_we x_rd x_vt x_addr        x_dout
    vt[0] = '{1'b1, 1'b0, 1'b0, 25'h01ABCDE, 16'h5A5A, 1'b1, 1'b0, 1'b0, 25'h01ABCDE, 16'h5A5A};
    vt[1] = '{1'b0, 1'b1, 1'b1, 25'h0000100, 16'h0000, 1'b0, 1'b1, 1'b1, 25'h0000100, 16'h0000};
    vt[2] = '{1'b1, 1'b1, 1'b0, 25'h00FFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 25'h00FFFFF, 16'hFFFF};
    vt[3] = '{1'b0, 1'b0, 1'b1, 25'h1FFFFFE, 16'h0001, 1'b0, 1'b0, 1'b1, 25'h1FFFFFE, 16'h0001};

    // reset state
    do_reset();
    chk("rst_cache_rd", cache_rd, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_mem_copy", mem_copy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dsk_gnt", dsk_gnt, 0);
    chk("rst_dsk_ack", dsk_ack, 0);
    chk("rst_sys_ready", sys_ready, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_copy_err", copy_err, 0);

    // boot copy
    push_boot(-1);
    release_reset(1'b0);
    run_to_ready(300);
    chk("boot_cpu_hold", cpu_hold, 0);
    chk("boot_copy_err", copy_err, 0);
    chk("boot_mem_copy", mem_copy, 0);
    chk("boot_left", exp_q.size(), 0);

    // disk grant and combinational pass-through
    ack_lat = 1000;
    dsk_req = 1'b1;
    step();
    chk("gnt", dsk_gnt, 1);
    chk("gnt_mem_copy", mem_copy, 1);
    chk("gnt_cpu_hold", cpu_hold, 1);
    for (int i = 0; i < 4; i++) begin
      dsk_we = vt[i].we; dsk_rd = vt[i].rd; dsk_virt = vt[i].virt;
      dsk_addr = vt[i].addr; dsk_dout = vt[i].dout;
      #1;
      chk("vec_we", mem_we, vt[i].x_we);
      chk("vec_rd", mem_rd, vt[i].x_rd);
      chk("vec_virt", mem_virt, vt[i].x_virt);
      chk("vec_addr", mem_addr, vt[i].x_addr);
      chk("vec_dout", mem_dout, vt[i].x_dout);
      step();
    end
    dsk_we = 1'b0; dsk_rd = 1'b0; dsk_virt = 1'b0;
    step();
    ack_lat = 3; rd_data = 16'hBEEF;
    dsk_rd = 1'b1; dsk_addr = 25'h0000100;
    n = 0;
    do begin step(); n++; end while (!dsk_ack && n < 20);
    chk("rd_dsk_ack", dsk_ack, 1);
    chk("rd_mem_ack_same", mem_ack, 1);
    chk("rd_dsk_din", dsk_din, 16'hBEEF);
    dsk_rd = 1'b0;
    step();
    chk("rd_ack_pulse", dsk_ack, 0);
    dsk_req = 1'b0;
    step();
    chk("drop_gnt", dsk_gnt, 0);
    chk("drop_mem_copy", mem_copy, 0);
    chk("drop_cpu_hold", cpu_hold, 0);

    // ack timeout on the second word
    do_reset();
    nak_en = 1'b1; nak_addr = BASE + 25'd2;
    push_boot(1);
    release_reset(1'b0);
    run_to_ready(400);
    chk("tmo_copy_err", copy_err, 1);
    chk("tmo_err_delay", err_cyc - nak_rise, ACK_TIMEOUT);
    chk("tmo_left", exp_q.size(), 0);
    nak_en = 1'b0;

    // reset during the MWR of the second word
    do_reset();
    push_word(0, 0);
    push_word(1, 3);
    reset = 1'b0;
    n = 0;
    do begin step(); n++; end while (!(mem_we && mem_addr == BASE + 25'd2) && n < 100);
    chk("mid_reached_mwr", mem_we, 1);
    reset = 1'b1;
    step();
    chk("mid_we_drop", mem_we, 0);
    chk("mid_sys_ready", sys_ready, 0);
    step();
    chk("mid_left", exp_q.size(), 0);
    push_boot(-1);
    release_reset(1'b0);
    run_to_ready(300);
    chk("mid_restart_left", exp_q.size(), 0);

    // disk request held from the first cycle after reset
    do_reset();
    dsk_addr = 25'h0123456;
    push_boot(-1);
    release_reset(1'b1);
    run_to_ready(300);
    chk("held_early_gnt", early_gnt, 0);
    chk("held_gnt_after_done", dsk_gnt, 1);
    chk("held_mem_addr", mem_addr, 25'h0123456);
    chk("held_cpu_hold", cpu_hold, 1);
    chk("held_left", exp_q.size(), 0);
    dsk_req = 1'b0;
    step();
    chk("held_release", dsk_gnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
